sirv_clint_icb_arb: RTL and testbench
=====================================

# sirv_clint_icb_arb

Two-master ICB arbiter that shares the single CLINT ICB slave port (msip/mtimecmp/mtime registers) between the core's private-peripheral port (master 0) and the debug/system-bus port (master 1). It sits directly in front of `sirv_clint_top`. It grants one master at a time and holds that grant until the command has been accepted. It allows one outstanding transaction and routes the response back to the owning master.

## Interface
- `AW`, 32, address width of all ICB ports
- `DW`, 32, data width of all ICB ports
- `clk`  in  1  sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `m0_icb_cmd_valid` / `m1_icb_cmd_valid`  in  1  master command valid
- `m0_icb_cmd_ready` / `m1_icb_cmd_ready`  out  1  master command ready
- `m0_icb_cmd_addr` / `m1_icb_cmd_addr`  in  AW  command address
- `m0_icb_cmd_read` / `m1_icb_cmd_read`  in  1  1 = read, 0 = write
- `m0_icb_cmd_wdata` / `m1_icb_cmd_wdata`  in  DW  write data
- `m0_icb_rsp_valid` / `m1_icb_rsp_valid`  out  1  response valid to master
- `m0_icb_rsp_ready` / `m1_icb_rsp_ready`  in  1  master response ready
- `m0_icb_rsp_rdata` / `m1_icb_rsp_rdata`  out  DW  read data to master
- `s_icb_cmd_valid`  out  1  command valid to CLINT
- `s_icb_cmd_ready`  in  1  CLINT command ready
- `s_icb_cmd_addr` / `s_icb_cmd_read` / `s_icb_cmd_wdata`  out  AW / 1 / DW  muxed command fields
- `s_icb_rsp_valid`  in  1  CLINT response valid
- `s_icb_rsp_ready`  out  1  CLINT response ready
- `s_icb_rsp_rdata`  in  DW  CLINT read data

## Operation
- FSM has three states.
  - IDLE: combinational pick among valid masters; the winner's cmd fields drive `s_icb_*`, and `s_icb_cmd_valid` = winner valid. The winner's `cmd_ready` = `s_icb_cmd_ready`; the loser's `cmd_ready` = 0. On cmd handshake: owner <= winner, go to RSP. If valid but not accepted: owner <= winner, go to HOLD.
  - HOLD: the owner's fields are forced to the slave, so the grant cannot switch while the command is pending (ICB stability rule). The other master gets `cmd_ready` = 0. On handshake, go to RSP. If the owner drops valid (protocol violation), return to IDLE.
  - RSP: both `cmd_ready` = 0.
    - `s_icb_rsp_valid` goes to the owner's `rsp_valid`; rdata goes to both masters' `rsp_rdata`.
    - `s_icb_rsp_ready` = the owner's `rsp_ready`.
    - Non-owner `rsp_valid` = 0.
    - On rsp handshake, go to IDLE.
- Outside RSP, `s_icb_rsp_ready` = 0 and both `m*_rsp_valid` = 0.
- The owner register is 1 bit. `last_grant` is 1 bit and updates only on cmd handshake.
- While `rst_n` = 0, all valid/ready outputs are driven 0. Data outputs are don't-care (driven from master 0).
- Reset values: state = IDLE, owner = 0, `last_grant` = 1 (master 0 has priority first).
- Reset mid-transaction abandons it; the CLINT response is not tracked after reset.

## Timing
- Zero-cycle command path: cmd can be accepted in the same cycle the master asserts valid (in IDLE).
- Response is combinational pass-through; adds no latency beyond the CLINT.
- Back-to-back: after the rsp handshake in cycle N, the next cmd can be accepted in cycle N+1. Minimum 2 cycles per transaction with a 1-cycle slave.
- Simultaneous valid in IDLE: decided by the arbitration mode (see Configuration).
- A master waiting in HOLD is never preempted.

## Configuration
- `SIRV_CLINT_ARB_RR_EN` defined: round-robin. On simultaneous valid, the master ≠ `last_grant` wins.
- Not defined: fixed priority. Master 0 always wins a tie. `last_grant` register is omitted.
- Single-requester behaviour is identical in both modes.

## Structure
- Shared package/header `sirv_clint_arb_pkg` holds:
  - state encodings `ARB_IDLE`=2'd0, `ARB_HOLD`=2'd1, `ARB_RSP`=2'd2
  - master index constants `ARB_M0`=1'b0, `ARB_M1`=1'b1
- Sub-module `sirv_clint_arb_pick`: 2-way picker (inputs: two valids, `last_grant`; outputs: grant index and any-valid). Contains the `SIRV_CLINT_ARB_RR_EN` branch.
- FSM, owner register and muxes live in the top.

## Test plan
- M0 reads 0x0200_BFF8 alone, slave ready = 1, rdata 0x0000_1234 one cycle later -> M0 cmd handshake in cycle 0; `m0_rsp_valid`=1 with rdata 0x1234 in cycle 1; `m1_rsp_valid` stays 0.
- M0 and M1 both valid in IDLE after reset -> M0 granted first. Next tie: with RR_EN, M1 granted; without RR_EN, M0 granted.
- M1 writes 0x0200_4000 data 0x0000_00FF; `s_icb_cmd_ready` held 0 for 3 cycles while M0 raises valid -> `s_icb_cmd_addr` stays 0x0200_4000 and `m0_cmd_ready`=0 throughout; M1 accepted in cycle 3.
- In RSP, owner M0 holds `rsp_ready`=0 for 2 cycles -> `s_icb_rsp_ready`=0 and no new cmd accepted; return to IDLE on the handshake cycle.
- `rst_n` pulled low during RSP for 1 cycle -> all valid/ready outputs 0 during reset; state IDLE afterwards; next tie grants M0.
- M1 drops valid while in HOLD -> FSM returns to IDLE next cycle; `s_icb_cmd_valid`=0; no response routed.

Source files
------------

// File: rtl/sirv_clint_arb_pkg.sv
// Shared encodings for the CLINT ICB two-master arbiter.
package sirv_clint_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_HOLD = 2'd1,
      ARB_RSP  = 2'd2
   } arb_state_e;

   localparam logic ARB_M0 = 1'b0;
   localparam logic ARB_M1 = 1'b1;

endpackage

// File: rtl/sirv_clint_arb_pick.sv
// 2-way request picker; round-robin when SIRV_CLINT_ARB_RR_EN is defined,
// fixed priority (master 0 wins) otherwise.
module sirv_clint_arb_pick
   import sirv_clint_arb_pkg::*;
(
   input  logic v0,
   input  logic v1,
   input  logic last_grant,
   output logic grant,
   output logic any_valid
);

   assign any_valid = v0 | v1;

`ifdef SIRV_CLINT_ARB_RR_EN
   // On a tie the master that did not win last time goes first.
   always_comb begin
      grant = ARB_M0;
      if (v0 && v1) grant = ~last_grant;
      else if (v1)  grant = ARB_M1;
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign grant = (!v0 && v1) ? ARB_M1 : ARB_M0;
`endif

endmodule

// File: rtl/sirv_clint_icb_arb.sv
// Shares the CLINT ICB slave between two masters, one outstanding transaction.
// Optional round-robin tie-break via SIRV_CLINT_ARB_RR_EN.
module sirv_clint_icb_arb
   import sirv_clint_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_icb_cmd_valid,
   output logic          m0_icb_cmd_ready,
   input  logic [AW-1:0] m0_icb_cmd_addr,
   input  logic          m0_icb_cmd_read,
   input  logic [DW-1:0] m0_icb_cmd_wdata,
   output logic          m0_icb_rsp_valid,
   input  logic          m0_icb_rsp_ready,
   output logic [DW-1:0] m0_icb_rsp_rdata,
   input  logic          m1_icb_cmd_valid,
   output logic          m1_icb_cmd_ready,
   input  logic [AW-1:0] m1_icb_cmd_addr,
   input  logic          m1_icb_cmd_read,
   input  logic [DW-1:0] m1_icb_cmd_wdata,
   output logic          m1_icb_rsp_valid,
   input  logic          m1_icb_rsp_ready,
   output logic [DW-1:0] m1_icb_rsp_rdata,
   output logic          s_icb_cmd_valid,
   input  logic          s_icb_cmd_ready,
   output logic [AW-1:0] s_icb_cmd_addr,
   output logic          s_icb_cmd_read,
   output logic [DW-1:0] s_icb_cmd_wdata,
   input  logic          s_icb_rsp_valid,
   output logic          s_icb_rsp_ready,
   input  logic [DW-1:0] s_icb_rsp_rdata
);

   arb_state_e state, state_nxt;
   logic       owner, owner_nxt;
   logic       last_grant;
   logic       pick_grant, pick_any;
   logic       sel, sel_valid, own_rsp_ready;
   logic       cmd_phase, rsp_phase, cmd_hs;

   sirv_clint_arb_pick u_pick (
      .v0         (m0_icb_cmd_valid),
      .v1         (m1_icb_cmd_valid),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .any_valid  (pick_any)
   );

   // Free pick only in IDLE; once a master owns the port it stays selected.
   assign sel           = (state == ARB_IDLE) ? pick_grant : owner;
   assign sel_valid     = (sel == ARB_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign own_rsp_ready = (owner == ARB_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
   assign cmd_hs        = cmd_phase & sel_valid & s_icb_cmd_ready;

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      cmd_phase = 1'b0;
      rsp_phase = 1'b0;
      case (state)
         ARB_IDLE: begin
            cmd_phase = 1'b1;
            if (pick_any) begin
               owner_nxt = pick_grant;
               state_nxt = s_icb_cmd_ready ? ARB_RSP : ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            cmd_phase = 1'b1;
            if (!sel_valid)           state_nxt = ARB_IDLE;
            else if (s_icb_cmd_ready) state_nxt = ARB_RSP;
         end
         ARB_RSP: begin
            rsp_phase = 1'b1;
            if (s_icb_rsp_valid && own_rsp_ready) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
         owner <= ARB_M0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

`ifdef SIRV_CLINT_ARB_RR_EN
   always_ff @(posedge clk) begin
      if (!rst_n)      last_grant <= ARB_M1;
      else if (cmd_hs) last_grant <= sel;
   end
`else
   assign last_grant = ARB_M1;
`endif

   // Handshake outputs are forced low while reset is asserted.
   assign s_icb_cmd_valid  = rst_n & cmd_phase & sel_valid;
   assign m0_icb_cmd_ready = rst_n & cmd_phase & (sel == ARB_M0) & s_icb_cmd_ready;
   assign m1_icb_cmd_ready = rst_n & cmd_phase & (sel == ARB_M1) & s_icb_cmd_ready;

   assign s_icb_cmd_addr  = (rst_n && sel == ARB_M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign s_icb_cmd_read  = (rst_n && sel == ARB_M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign s_icb_cmd_wdata = (rst_n && sel == ARB_M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;

   assign s_icb_rsp_ready  = rst_n & rsp_phase & own_rsp_ready;
   assign m0_icb_rsp_valid = rst_n & rsp_phase & (owner == ARB_M0) & s_icb_rsp_valid;
   assign m1_icb_rsp_valid = rst_n & rsp_phase & (owner == ARB_M1) & s_icb_rsp_valid;
   assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

endmodule

// File: tb/tb_sirv_clint_icb_arb.sv
// Directed bench for sirv_clint_icb_arb with a transaction-level reference model.
module tb_sirv_clint_icb_arb;

`ifdef SIRV_CLINT_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   localparam int FREE = 0, WAIT_ACC = 1, WAIT_RSP = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        m0v, m0rdy, m0rd, m0rv, m0rr;
   logic        m1v, m1rdy, m1rd, m1rv, m1rr;
   logic [31:0] m0a, m0wd, m0rdata, m1a, m1wd, m1rdata;
   logic        scv, scr, srd, srv, srr;
   logic [31:0] sa, swd, srdata;

   int errors = 0, checks = 0;

   sirv_clint_icb_arb #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_icb_cmd_valid(m0v), .m0_icb_cmd_ready(m0rdy), .m0_icb_cmd_addr(m0a),
      .m0_icb_cmd_read(m0rd), .m0_icb_cmd_wdata(m0wd), .m0_icb_rsp_valid(m0rv),
      .m0_icb_rsp_ready(m0rr), .m0_icb_rsp_rdata(m0rdata),
      .m1_icb_cmd_valid(m1v), .m1_icb_cmd_ready(m1rdy), .m1_icb_cmd_addr(m1a),
      .m1_icb_cmd_read(m1rd), .m1_icb_cmd_wdata(m1wd), .m1_icb_rsp_valid(m1rv),
      .m1_icb_rsp_ready(m1rr), .m1_icb_rsp_rdata(m1rdata),
      .s_icb_cmd_valid(scv), .s_icb_cmd_ready(scr), .s_icb_cmd_addr(sa),
      .s_icb_cmd_read(srd), .s_icb_cmd_wdata(swd), .s_icb_rsp_valid(srv),
      .s_icb_rsp_ready(srr), .s_icb_rsp_rdata(srdata)
   );

   task automatic chk1(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Who gets the port when it is free.
   function automatic int pick(input bit a, input bit b, input int prev);
      if (a && b) return RR ? 1 - prev : 0;
      return (!a && b) ? 1 : 0;
   endfunction

   // Reference model: transaction phase, owning master, last accepted master.
   int ph = FREE, own = 0, prev = 1;

   always @(negedge clk) begin
      int  s;
      bit  v0, v1, vs, rr_own, e_scv;
      v0 = m0v; v1 = m1v;
      s  = (ph == FREE) ? pick(v0, v1, prev) : own;
      vs = (s == 1) ? v1 : v0;
      rr_own = (own == 1) ? m1rr : m0rr;
      e_scv  = rst_n && (ph != WAIT_RSP) && vs;
      chk1 ("scv", scv, e_scv);
      chk1 ("m0rdy", m0rdy, rst_n && ph != WAIT_RSP && s == 0 && scr);
      chk1 ("m1rdy", m1rdy, rst_n && ph != WAIT_RSP && s == 1 && scr);
      chk1 ("m0rv", m0rv, rst_n && ph == WAIT_RSP && own == 0 && srv);
      chk1 ("m1rv", m1rv, rst_n && ph == WAIT_RSP && own == 1 && srv);
      chk1 ("srr", srr, rst_n && ph == WAIT_RSP && rr_own);
      chk32("m0rdata", m0rdata, srdata);
      chk32("m1rdata", m1rdata, srdata);
      if (!rst_n || s == 0) begin
         chk32("saddr", sa, m0a); chk32("swdata", swd, m0wd); chk1("sread", srd, m0rd);
      end else begin
         chk32("saddr", sa, m1a); chk32("swdata", swd, m1wd); chk1("sread", srd, m1rd);
      end
      if (!rst_n) begin
         ph = FREE; own = 0; prev = 1;
      end else if (ph == FREE) begin
         if (v0 || v1) begin
            own = s;
            if (scr) begin ph = WAIT_RSP; prev = s; end
            else ph = WAIT_ACC;
         end
      end else if (ph == WAIT_ACC) begin
         if (!vs) ph = FREE;
         else if (scr) begin ph = WAIT_RSP; prev = own; end
      end else if (srv && rr_own) begin
         ph = FREE;
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clr();
      m0v = 0; m1v = 0; scr = 0; srv = 0; m0rr = 0; m1rr = 0;
   endtask

   task automatic do_reset();
      step(); rst_n = 0; clr();
      step(); rst_n = 1;
   endtask

   initial begin
      rst_n = 0; clr();
      m0a = 32'h0; m0rd = 0; m0wd = 32'h0; m1a = 32'h0; m1rd = 0; m1wd = 32'h0;
      srdata = 32'h0;

      // reset forces all handshakes low even with every input active
      step(); step();
      m0v = 1; m1v = 1; scr = 1; srv = 1; m0rr = 1; m1rr = 1; #1;
      chk1("rst_scv", scv, 1'b0); chk1("rst_m0rdy", m0rdy, 1'b0);
      chk1("rst_m0rv", m0rv, 1'b0); chk1("rst_srr", srr, 1'b0);

      // single M0 read, 1-cycle slave
      do_reset(); clr();
      m0v = 1; m0a = 32'h0200_BFF8; m0rd = 1; scr = 1; #1;
      chk1("t1_m0rdy", m0rdy, 1'b1); chk32("t1_saddr", sa, 32'h0200_BFF8);
      step(); clr(); srv = 1; srdata = 32'h0000_1234; m0rr = 1; #1;
      chk1("t1_m0rv", m0rv, 1'b1); chk32("t1_rdata", m0rdata, 32'h0000_1234);
      chk1("t1_m1rv", m1rv, 1'b0);

      // ties after reset
      do_reset(); clr();
      m0v = 1; m1v = 1; m1a = 32'h0200_0004; scr = 1; #1;
      chk1("t2_tie1_m0", m0rdy, 1'b1); chk1("t2_tie1_m1", m1rdy, 1'b0);
      step(); clr(); srv = 1; m0rr = 1; m1rr = 1; #1;
      chk1("t2_rsp_m0", m0rv, 1'b1);
      step(); clr(); m0v = 1; m1v = 1; scr = 1; #1;
      chk1("t2_tie2_m1", m1rdy, RR); chk1("t2_tie2_m0", m0rdy, !RR);
      step(); clr(); srv = 1; m0rr = 1; m1rr = 1;

      // M1 held in HOLD for 3 cycles while M0 requests
      do_reset(); clr();
      m1v = 1; m1a = 32'h0200_4000; m1rd = 0; m1wd = 32'h0000_00FF; #1;
      chk32("t3_addr_c0", sa, 32'h0200_4000); chk1("t3_m0rdy_c0", m0rdy, 1'b0);
      for (int i = 1; i < 3; i++) begin
         step(); m0v = 1; m0a = 32'h0200_0000; m0rd = 1; #1;
         chk32("t3_addr_hold", sa, 32'h0200_4000); chk1("t3_m0rdy_hold", m0rdy, 1'b0);
      end
      step(); scr = 1; #1;
      chk1("t3_m1_acc", m1rdy, 1'b1); chk1("t3_m0rdy_c3", m0rdy, 1'b0);
      chk32("t3_wdata", swd, 32'h0000_00FF);
      step(); m1v = 0; srv = 1; srdata = 32'h0; m1rr = 1; #1;
      chk1("t3_m1rv", m1rv, 1'b1); chk1("t3_m0rdy_rsp", m0rdy, 1'b0);
      step(); srv = 0; m1rr = 0; #1;
      chk1("t3_m0_acc", m0rdy, 1'b1);

      // owner M0 stalls its response for 2 cycles while M1 requests
      step(); m0v = 0; m1v = 1; srv = 1; srdata = 32'hA5A5_0001; m0rr = 0; #1;
      chk1("t4_srr0", srr, 1'b0); chk1("t4_m1rdy0", m1rdy, 1'b0);
      step(); #1;
      chk1("t4_srr1", srr, 1'b0); chk1("t4_m1rdy1", m1rdy, 1'b0);
      step(); m0rr = 1; #1;
      chk1("t4_srr_hs", srr, 1'b1); chk1("t4_m0rv_hs", m0rv, 1'b1);
      step(); srv = 0; m0rr = 0; #1;
      chk1("t4_b2b_m1", m1rdy, 1'b1);
      step(); m1v = 0; srv = 1; m1rr = 1;

      // reset during RSP abandons the transaction
      step(); clr(); m0v = 1; scr = 1; #1;
      chk1("t5_m0_acc", m0rdy, 1'b1);
      step(); rst_n = 0; m1v = 1; srv = 1; m0rr = 1; m1rr = 1; #1;
      chk1("t5_scv", scv, 1'b0); chk1("t5_m0rv", m0rv, 1'b0);
      chk1("t5_srr", srr, 1'b0); chk1("t5_m1rdy", m1rdy, 1'b0);
      step(); rst_n = 1; clr(); m0v = 1; m1v = 1; scr = 1; #1;
      chk1("t5_tie_m0", m0rdy, 1'b1); chk1("t5_tie_m1", m1rdy, 1'b0);
      step(); clr(); srv = 1; m0rr = 1;

      // M1 drops valid in HOLD
      step(); clr(); m1v = 1; #1;
      chk1("t6_scv", scv, 1'b1);
      step(); m1v = 0; #1;
      chk1("t6_scv_drop", scv, 1'b0);
      step(); srv = 1; m0rr = 1; m1rr = 1; #1;
      chk1("t6_m1rv", m1rv, 1'b0); chk1("t6_srr", srr, 1'b0);
      step(); clr();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
